// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit with architectural HI/LO registers.
// Results are computed at issue and released after a configurable busy period.
module ex_mdu #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES) + 1;
    localparam int unsigned W2         = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [0:0] {IDLE, BUSY} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic             pend_wr;

    logic             is_long_c;
    logic             is_mult_c;
    logic             signed_c;
    logic [W2-1:0]    a_ext;
    logic [W2-1:0]    b_ext;
    logic [W2-1:0]    prod;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] b_safe;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             res_wr;

    assign is_long_c = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign is_mult_c = (op == OP_MULT) || (op == OP_MULTU);
    assign signed_c  = (op == OP_MULT) || (op == OP_DIV);
    assign stall     = busy | (start & is_long_c);

    // Full result computed at issue; signed multiply uses sign-extended operands, divide works on magnitudes.
    always_comb begin
        a_ext  = {{WIDTH{signed_c & src_a[WIDTH-1]}}, src_a};
        b_ext  = {{WIDTH{signed_c & src_b[WIDTH-1]}}, src_b};
        prod   = a_ext * b_ext;
        a_neg  = signed_c & src_a[WIDTH-1];
        b_neg  = signed_c & src_b[WIDTH-1];
        a_mag  = a_neg ? -src_a : src_a;
        b_mag  = b_neg ? -src_b : src_b;
        b_safe = (b_mag == '0) ? WIDTH'(1) : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem    = a_neg ? -r_mag : r_mag;
        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b1;
        if (is_mult_c) begin
            res_hi = prod[W2-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else begin
            res_hi = rem;
            res_lo = quot;
            res_wr = (src_b != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi_out  <= '0;
            lo_out  <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_long_c) begin
                            pend_hi <= res_hi;
                            pend_lo <= res_lo;
                            pend_wr <= res_wr;
                            cnt     <= is_mult_c ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
                            busy    <= 1'b1;
                            state   <= BUSY;
                        end else if (op == OP_MTHI) begin
                            hi_out <= src_a;
                        end else if (op == OP_MTLO) begin
                            lo_out <= src_a;
                        end
                    end
                end
                BUSY: begin
                    // Issue is blocked while busy, so start/op are not looked at here.
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        if (pend_wr) begin
                            hi_out <= pend_hi;
                            lo_out <= pend_lo;
                        end
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed vector table, corner sequences, and randomized ops vs a reference model.
module tb_ex_mdu;

    localparam int W      = 32;
    localparam int NMULT  = 5;
    localparam int NDIV   = 10;
    localparam int LIMIT  = 100;

    logic          clk;
    logic          reset;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          busy;
    logic          stall;
    logic          done;
    logic [W-1:0]  hi_out;
    logic [W-1:0]  lo_out;

    int n_checks;
    int n_fail;
    logic [W-1:0] mhi;
    logic [W-1:0] mlo;

    ex_mdu #(.WIDTH(W), .MULT_CYCLES(NMULT), .DIV_CYCLES(NDIV)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .stall(stall),
        .done(done), .hi_out(hi_out), .lo_out(lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an MDU op from plain signed/unsigned arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] h,
                                          input logic [W-1:0] l);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            3'd1: return 64'(sa * sb);
            3'd2: return ua * ub;
            3'd3: begin
                if (b == '0) return {h, l};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == '0) return {h, l};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return {h, l};
        endcase
    endfunction

    // Issue a long op at the current negedge; returns at the negedge where done is high.
    task automatic run_long(input string name, input logic [2:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] eh,
                            input logic [W-1:0] el, input int inject_at);
        int cnt;
        int n;
        logic [W-1:0] h0, l0;
        n = (o == 3'd1 || o == 3'd2) ? NMULT : NDIV;
        h0 = hi_out;
        l0 = lo_out;
        start = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        check({name, " stall_at_issue"}, 64'(stall), 64'd1);
        @(negedge clk);
        cnt = 0;
        while (busy && cnt < LIMIT) begin
            cnt++;
            check({name, " done_low_while_busy"}, 64'(done), 64'd0);
            check({name, " hilo_held_while_busy"}, {hi_out, lo_out}, {h0, l0});
            if (cnt == inject_at) begin
                start = 1'b1; op = 3'b101; src_a = 32'hAA;
            end else begin
                start = 1'b0; op = 3'b000;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({name, " busy_cycles"}, 64'(cnt), 64'(n));
        check({name, " done_pulse"}, 64'(done), 64'd1);
        check({name, " hi"}, 64'(hi_out), 64'(eh));
        check({name, " lo"}, 64'(lo_out), 64'(el));
        mhi = hi_out;
        mlo = lo_out;
    endtask

    task automatic run_move(input string name, input logic [2:0] o, input logic [W-1:0] a);
        start = 1'b1; op = o; src_a = a; src_b = '0;
        #1;
        check({name, " stall"}, 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0; op = 3'b000;
        if (o == 3'b101) mhi = a; else mlo = a;
        check({name, " hilo"}, {hi_out, lo_out}, {mhi, mlo});
        check({name, " busy"}, 64'(busy), 64'd0);
        check({name, " done"}, 64'(done), 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        logic [63:0] exp;
        logic [2:0]  ro;
        logic [W-1:0] ra, rb;

        n_checks = 0;
        n_fail   = 0;
        mhi = '0;
        mlo = '0;
        reset = 1'b1; start = 1'b0; op = 3'b000; src_a = '0; src_b = '0;

        vecs[0] = '{3'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4] = '{3'd4, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[5] = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset hi", 64'(hi_out), 64'd0);
        check("reset lo", 64'(lo_out), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset stall", 64'(stall), 64'd0);

        // Back-to-back: each vector issues in the done cycle of the previous one.
        for (int i = 0; i < 6; i++) begin
            run_long($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].exp_hi, vecs[i].exp_lo, -1);
        end
        @(negedge clk);
        check("done falls", 64'(done), 64'd0);

        run_move("mthi", 3'b101, 32'h11);
        run_move("mtlo", 3'b110, 32'h22);
        run_long("divu_by_zero", 3'd4, 32'd7, 32'd0, 32'h11, 32'h22, -1);
        @(negedge clk);

        run_long("mult_ignore_mthi", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 2);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(1, 4));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            exp = model(ro, ra, rb, mhi, mlo);
            run_long($sformatf("rand%0d", i), ro, ra, rb, exp[63:32], exp[31:0], -1);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        @(negedge clk);

        // Reset arriving mid-operation discards the pending result.
        start = 1'b1; op = 3'd1; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0; op = 3'b000;
        repeat (2) @(negedge clk);
        check("pre_reset busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset hilo", {hi_out, lo_out}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            check("midreset no_done", 64'(done), 64'd0);
            @(negedge clk);
        end
        check("midreset hilo_final", {hi_out, lo_out}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Parametrised multi-cycle multiply/divide unit for the EX stage, with architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU with configurable latency. Executes MTHI/MTLO in a single cycle.
- Drives a stall request to the hazard unit so that mult/div/MFHI/MFLO instructions hold in ID while the unit is busy.
- Operands arrive already forwarded from the EX-stage forwarding muxes.

Parameters:
- WIDTH, 32, operand and HI/LO register width in bits.
- MULT_CYCLES, 5, cycles busy is high for MULT/MULTU (legal range ≥1).
- DIV_CYCLES, 10, cycles busy is high for DIV/DIVU (legal range ≥1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  EX-stage instruction is an MDU op this cycle (already qualified by pipeline valid).
- op  input  3  001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 000/111 no-op.
- src_a  input  WIDTH  forwarded rs value (multiplicand/dividend, MTHI/MTLO data).
- src_b  input  WIDTH  forwarded rt value (multiplier/divisor).
- busy  output  1  long operation in flight.
- stall  output  1  combinational: busy | (start & op∈{001..100}).
- done  output  1  one-cycle pulse, high in the cycle new HI/LO from a mult/div first become visible.
- hi_out  output  WIDTH  HI register.
- lo_out  output  WIDTH  LO register.

Behaviour:
- Decided: one clock; reset is synchronous and active-high (ports clk, reset). All state updates on the rising clk edge.
- Reset (wins over every other input, including mid-operation):
  - hi_out=0, lo_out=0, busy=0, done=0; state IDLE; counter=0.
  - Any pending result is discarded.
- State machine, IDLE/BUSY; counter width = clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU:
  - Capture op and operands (or the precomputed 2·WIDTH result) into pending registers.
  - busy<=1; counter <= N−1, where N = MULT_CYCLES or DIV_CYCLES; go to BUSY.
- IDLE, start=1, op MTHI/MTLO: hi_out (or lo_out) <= src_a at this edge; busy stays 0; done stays 0.
- IDLE, start=0 or op 000/111: no state change.
- BUSY, counter≠0: counter−1.
- BUSY, counter==0:
  - Write pending result to HI/LO; busy<=0; done<=1; go to IDLE.
  - busy is therefore high for exactly N cycles after the start edge.
  - HI/LO change at the same edge busy falls.
- BUSY: start and op are ignored entirely (including MTHI/MTLO). The hazard unit guarantees no issue while stall=1; the bench checks that HI/LO are unaffected.
- done is high only for the single cycle after the write edge; it is 0 otherwise.
- Multiply results:
  - MULT: signed WIDTH×WIDTH→2·WIDTH product; HI = upper WIDTH bits, LO = lower WIDTH bits.
  - MULTU: the same, unsigned.
- DIV (signed):
  - Quotient truncates toward zero → LO.
  - Remainder takes the sign of the dividend → HI.
- Overflow case −2^(WIDTH−1) / −1: LO = −2^(WIDTH−1), HI = 0. No trap.
- DIVU: unsigned quotient → LO, remainder → HI.
- Divisor 0 (DIV or DIVU):
  - Full DIV_CYCLES busy period and done pulse still occur.
  - HI and LO keep their previous values.
- Back-to-back: a new start is accepted in the cycle done=1, since the FSM is already IDLE. There is no dead cycle.
- hi_out/lo_out are register outputs. Reads during BUSY return the old values; the stall output prevents MFHI/MFLO from consuming them.

Test Plan:
- reset=1 for 2 cycles then released → hi_out=0, lo_out=0, busy=0, done=0, stall=0.
- MULT, src_a=0xFFFFFFFD (−3), src_b=5 →
  - stall=1 in the start cycle.
  - busy=1 for exactly 5 cycles.
  - Then hi_out=0xFFFFFFFF, lo_out=0xFFFFFFF1, done=1 for one cycle.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 5 busy cycles, hi_out=0xFFFFFFFE, lo_out=0x00000001.
- DIV −7/2 → after 10 busy cycles, lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → lo_out=0x80000000, hi_out=0.
- HI=0x11, LO=0x22 set via MTHI/MTLO (each visible the next cycle, busy never set), then DIVU 7/0 → done pulses after 10 cycles; HI=0x11, LO=0x22 unchanged.
- MULT started, then in BUSY cycle 2 drive start=1 op=MTHI src_a=0xAA → ignored; MULT result is written on schedule.
- Separately, reset asserted in BUSY cycle 3 → next cycle busy=0, HI=LO=0, and no done pulse follows.
